sid_bass_sequencer: RTL and testbench
=====================================

SID_BASS_SEQUENCER -- requirements
Module: sid_bass_sequencer

Interface
REQ-001 The block SHALL have parameter GATE_GAP, default 2: number of ticks at the end of each step during which gate is low.
REQ-002 The block SHALL have parameter TICK_BITS, default 16: tick occurs when all prescaler[TICK_BITS-1:0] bits are 1.
REQ-003 The block SHALL have port clk, input, 1: sole clock.
REQ-004 The block SHALL have port rst_n, input, 1: reset, synchronous to clk, active low.
REQ-005 The block SHALL have port prescaler, input, 16: free-running prescaler shared with the voices.
REQ-006 The block SHALL have port run, input, 1: level; 1 = play pattern, 0 = stop.
REQ-007 The block SHALL have port step_len, input, 8: each step lasts step_len+1 ticks.
REQ-008 The block SHALL have port wr_en, input, 1: pattern write strobe.
REQ-009 The block SHALL have port wr_addr, input, 4: pattern entry index.
REQ-010 The block SHALL have port wr_data, input, 8: entry; bit7 = rest flag, bits[6:0] = frequency.
REQ-011 The block SHALL have port frequency, output, 7: phase increment to the voice.
REQ-012 The block SHALL have port gate, output, 1: envelope gate to the voice.
REQ-013 The block SHALL have port step, output, 4: index of the current step.
REQ-014 The block SHALL have port step_strobe, output, 1: one-cycle pulse at each step start.
REQ-015 The block SHALL have port running, output, 1: high in PLAY.

Function
REQ-016 The pattern SHALL be held in a 16 x 8 register file; a write with wr_en=1 SHALL update entry wr_addr at the clock edge, in any state.
REQ-017 The FSM SHALL have two states: IDLE and PLAY.
REQ-018 In IDLE with run=1, the next edge SHALL enter PLAY, set step=0, set tick_cnt=0, pulse step_strobe, and load entry 0.
REQ-019 Loading an entry SHALL set frequency to bits[6:0] if bit7=0; if bit7=1 (rest), frequency SHALL hold its previous value.
REQ-020 In PLAY, each tick with tick_cnt<step_len SHALL increment tick_cnt.
REQ-021 In PLAY, a tick with tick_cnt>=step_len SHALL clear tick_cnt, advance step (wrapping at the loop end), pulse step_strobe, and load the new entry, all on the same edge.
REQ-022 gate SHALL be a register, equal to 1 iff state=PLAY, the current entry is not a rest, and tick_cnt < step_len+1-GATE_GAP, computed at 10-bit width with a negative result treated as 0.
REQ-023 The gate comparison SHALL use the registered tick_cnt and step values after the edge, so that gate changes on the same edge as tick_cnt.
REQ-024 A change of step_len mid-step SHALL take effect at the next tick comparison.
REQ-025 run=0 in PLAY SHALL return the FSM to IDLE on the next edge, with gate=0 and running=0; frequency and step SHALL hold.
REQ-026 Step loads SHALL sample the register file before any same-edge write, so a write to the entry being loaded is seen on the next pass only.
REQ-027 step_strobe SHALL be exactly one cycle wide and SHALL never assert in IDLE except on the start edge.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL set: state=IDLE, tick_cnt=0, step=0, frequency=0, gate=0, step_strobe=0, running=0, and all pattern entries to 8'h80 (rest).
REQ-029 Reset SHALL override run and wr_en on the same edge, including when asserted mid-step.

Configuration
REQ-030 With SID_SEQ_LOOP_LEN_EN defined, the block SHALL have an extra input loop_end[3:0], and step SHALL wrap from loop_end to 0; a step already greater than loop_end SHALL wrap to 0 at its next advance.
REQ-031 Without SID_SEQ_LOOP_LEN_EN, there SHALL be no loop_end port, and step SHALL wrap from 15 to 0.

Structure
REQ-032 The shared package sid_pkg SHALL hold SEQ_STEPS=16, SEQ_REST_BIT=7, and the IDLE/PLAY state encoding.
REQ-033 The register file SHALL be the sub-module sid_seq_pattern_ram, with one synchronous write port and one asynchronous read port.

Verification
REQ-034 Reset check: drive rst_n=0 for 2 cycles -> all outputs are 0, and every entry read back is 8'h80.
REQ-035 Basic play: write entries 0..3 = 22, 17, 20, 22; set step_len=3 and run=1 -> step runs 0,1,2,3,4 with 4 ticks per step; frequency is 22,17,20,22; gate is high for 2 ticks and low for 2 ticks per step.
REQ-036 Rest: write entry 1 = 8'h91 and play -> gate stays 0 for the whole of step 1, and frequency stays 22.
REQ-037 Short step: step_len=1 with GATE_GAP=2 -> gate is never 1, while step_strobe still pulses every 2 ticks.
REQ-038 Stop/restart: drop run mid-step 5 -> gate=0 on the next edge and step holds at 5; raise run again -> step=0 with a strobe.
REQ-039 Wrap and write collision: play through 15->0 (or loop_end=3 under the macro, giving 3->0), and write entry 0 on the wrap edge -> the old value is loaded and the new value is loaded on the next pass.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared constants and types for the SID bass step sequencer.
package sid_pkg;

    localparam int unsigned SEQ_STEPS    = 16;
    localparam int unsigned SEQ_REST_BIT = 7;
    localparam int unsigned SEQ_ADDR_W   = 4;
    localparam int unsigned SEQ_DATA_W   = 8;
    localparam int unsigned SEQ_FREQ_W   = 7;
    localparam int unsigned SEQ_TICK_W   = 8;
    localparam int unsigned SEQ_GATE_W   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic                  rest;
        logic [SEQ_FREQ_W-1:0] freq;
    } seq_entry_t;

endpackage

// File: rtl/sid_seq_pattern_ram.sv
// 16 x 8 pattern register file: one synchronous write port, one asynchronous read port.
module sid_seq_pattern_ram
    import sid_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [SEQ_ADDR_W-1:0] wr_addr,
    input  logic [SEQ_DATA_W-1:0] wr_data,
    input  logic [SEQ_ADDR_W-1:0] rd_addr,
    output logic [SEQ_DATA_W-1:0] rd_data_c
);

    logic [SEQ_DATA_W-1:0] mem [SEQ_STEPS];

    // Reset fills every entry with a rest so an unprogrammed pattern stays silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SEQ_STEPS); i++) begin
                mem[i] <= SEQ_DATA_W'(1 << SEQ_REST_BIT);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/sid_bass_sequencer.sv
// Bass step sequencer driving one SID voice from a 16-entry pattern.
// Optional SID_SEQ_LOOP_LEN_EN adds a loop_end input that shortens the loop.
module sid_bass_sequencer
    import sid_pkg::*;
#(
    parameter int unsigned GATE_GAP  = 2,
    parameter int unsigned TICK_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           prescaler,
    input  logic                  run,
    input  logic [7:0]            step_len,
    input  logic                  wr_en,
    input  logic [SEQ_ADDR_W-1:0] wr_addr,
    input  logic [SEQ_DATA_W-1:0] wr_data,
`ifdef SID_SEQ_LOOP_LEN_EN
    input  logic [SEQ_ADDR_W-1:0] loop_end,
`endif
    output logic [SEQ_FREQ_W-1:0] frequency,
    output logic                  gate,
    output logic [SEQ_ADDR_W-1:0] step,
    output logic                  step_strobe,
    output logic                  running
);

    seq_state_t            state_q, state_d;
    logic [SEQ_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SEQ_ADDR_W-1:0] step_d, step_next_c, rd_addr_c;
    logic [SEQ_FREQ_W-1:0] freq_d;
    logic                  rest_q, rest_d;
    logic                  gate_d, strobe_d, running_d;
    logic                  tick_c, wrap_c, load_c;
    logic [SEQ_DATA_W-1:0] rd_data_c;
    seq_entry_t            rd_entry_c;
    logic [SEQ_GATE_W-1:0] gate_span_c, gate_lim_c;

    sid_seq_pattern_ram u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    assign tick_c     = &prescaler[TICK_BITS-1:0];
    assign rd_entry_c = seq_entry_t'(rd_data_c);

`ifdef SID_SEQ_LOOP_LEN_EN
    assign wrap_c = (step >= loop_end);
`else
    assign wrap_c = (step == SEQ_ADDR_W'(SEQ_STEPS - 1));
`endif
    assign step_next_c = wrap_c ? '0 : step + SEQ_ADDR_W'(1);

    // Start always loads entry 0; an advance loads the step being entered.
    assign rd_addr_c = (state_q == IDLE) ? '0 : step_next_c;

    // Gate window length, clamped at zero when the gap swallows the whole step.
    assign gate_span_c = SEQ_GATE_W'(step_len) + SEQ_GATE_W'(1);
    assign gate_lim_c  = (gate_span_c > SEQ_GATE_W'(GATE_GAP)) ?
                         gate_span_c - SEQ_GATE_W'(GATE_GAP) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            step        <= '0;
            frequency   <= '0;
            rest_q      <= 1'b1;
            gate        <= 1'b0;
            step_strobe <= 1'b0;
            running     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            step        <= step_d;
            frequency   <= freq_d;
            rest_q      <= rest_d;
            gate        <= gate_d;
            step_strobe <= strobe_d;
            running     <= running_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        step_d     = step;
        freq_d     = frequency;
        rest_d     = rest_q;
        strobe_d   = 1'b0;
        load_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d    = PLAY;
                    tick_cnt_d = '0;
                    step_d     = '0;
                    strobe_d   = 1'b1;
                    load_c     = 1'b1;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (tick_c) begin
                    if (tick_cnt_q < step_len) begin
                        tick_cnt_d = tick_cnt_q + SEQ_TICK_W'(1);
                    end else begin
                        tick_cnt_d = '0;
                        step_d     = step_next_c;
                        strobe_d   = 1'b1;
                        load_c     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A rest entry keeps the previous pitch and only silences the gate.
        if (load_c) begin
            rest_d = rd_entry_c.rest;
            if (!rd_entry_c.rest) begin
                freq_d = rd_entry_c.freq;
            end
        end

        gate_d    = (state_d == PLAY) && !rest_d &&
                    (SEQ_GATE_W'(tick_cnt_d) < gate_lim_c);
        running_d = (state_d == PLAY);
    end

endmodule

// File: tb/tb_sid_bass_sequencer.sv
// Self-checking bench for sid_bass_sequencer against a per-edge behavioural model.
module tb_sid_bass_sequencer;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n, run, wr_en;
    logic [15:0] prescaler;
    logic [7:0]  step_len, wr_data;
    logic [3:0]  wr_addr;
    logic [6:0]  frequency;
    logic        gate, step_strobe, running;
    logic [3:0]  step;
    int          last_step = 15;
`ifdef SID_SEQ_LOOP_LEN_EN
    logic [3:0]  loop_end;
    assign loop_end = 4'(last_step);
`endif

    int checks = 0;
    int failures = 0;

    bit m_play, m_rest, m_gate, m_strobe;
    int m_step, m_tick, m_freq;
    int m_pat[16];

    always #5 clk = ~clk;

    sid_bass_sequencer #(.GATE_GAP(GAP), .TICK_BITS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prescaler   (prescaler),
        .run         (run),
        .step_len    (step_len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef SID_SEQ_LOOP_LEN_EN
        .loop_end    (loop_end),
`endif
        .frequency   (frequency),
        .gate        (gate),
        .step        (step),
        .step_strobe (step_strobe),
        .running     (running)
    );

    // Advance one clock edge and apply the sequencer rules to the model.
    task automatic cycle();
        int old_pat[16];
        int v, lim;
        bit tk;
        @(posedge clk);
        tk = (prescaler == 16'hFFFF);
        old_pat = m_pat;
        v = -1;
        if (!rst_n) begin
            m_play = 0; m_step = 0; m_tick = 0; m_freq = 0; m_rest = 1; m_strobe = 0;
            foreach (m_pat[i]) m_pat[i] = 8'h80;
        end else begin
            m_strobe = 0;
            if (wr_en) m_pat[wr_addr] = int'(wr_data);
            if (!m_play) begin
                if (run) begin
                    m_play = 1; m_step = 0; m_tick = 0; m_strobe = 1; v = old_pat[0];
                end
            end else if (!run) begin
                m_play = 0;
            end else if (tk) begin
                if (m_tick < int'(step_len)) m_tick++;
                else begin
                    m_tick = 0;
                    m_step = (m_step >= last_step) ? 0 : m_step + 1;
                    m_strobe = 1;
                    v = old_pat[m_step];
                end
            end
        end
        if (v >= 0) begin
            m_rest = (v >= 128);
            if (!m_rest) m_freq = v % 128;
        end
        lim = int'(step_len) + 1 - GAP;
        if (lim < 0) lim = 0;
        m_gate = m_play && !m_rest && (m_tick < lim);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; run = 1; wr_en = 1; wr_addr = 0; wr_data = 8'h10;
        prescaler = 16'hFFFF; step_len = 0;
        repeat (2) begin
            cycle();
            checks++;
            if ({frequency, gate, step, step_strobe, running} !== 14'd0) begin
                failures++;
                $display("FAIL reset_outputs got f=%0d g=%b s=%0d st=%b r=%b exp all 0",
                         frequency, gate, step, step_strobe, running);
            end
        end
        rst_n = 1; wr_en = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (frequency !== 7'd0 || gate !== 1'b0 || step !== 4'(m_step)) begin
                failures++;
                $display("FAIL reset_entries_rest got f=%0d g=%b s=%0d exp f=0 g=0 s=%0d",
                         frequency, gate, step, m_step);
            end
        end
        run = 0;
        cycle();
    endtask

    task automatic test_basic_play();
        int vals[4] = '{22, 17, 20, 22};
        int gh, sc;
        run = 0; gh = 0; sc = 0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 8'(vals[i]);
            cycle();
        end
        wr_en = 0; step_len = 3; prescaler = 16'hFFFF; run = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            gh += int'(gate); sc += int'(step_strobe);
            checks++;
            if ({frequency, gate, step, step_strobe, running} !==
                {7'(m_freq), m_gate, 4'(m_step), m_strobe, m_play}) begin
                failures++;
                $display("FAIL basic got f=%0d g=%b s=%0d st=%b r=%b exp f=%0d g=%b s=%0d st=%b r=%b",
                         frequency, gate, step, step_strobe, running,
                         m_freq, m_gate, m_step, m_strobe, m_play);
            end
        end
        checks++;
        if (gh != 8 || sc != 5) begin
            failures++;
            $display("FAIL basic_counts got gate_hi=%0d strobes=%0d exp 8 5", gh, sc);
        end
        run = 0;
        cycle();
    endtask

    task automatic test_rest();
        wr_en = 1; wr_addr = 1; wr_data = 8'h91;
        cycle();
        wr_en = 0; step_len = 3; run = 1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            checks++;
            if ({frequency, gate, step, step_strobe, running} !==
                {7'(m_freq), m_gate, 4'(m_step), m_strobe, m_play}) begin
                failures++;
                $display("FAIL rest got f=%0d g=%b s=%0d st=%b exp f=%0d g=%b s=%0d st=%b",
                         frequency, gate, step, step_strobe, m_freq, m_gate, m_step, m_strobe);
            end
            if (step == 4'd1) begin
                checks++;
                if (gate !== 1'b0 || frequency !== 7'd22) begin
                    failures++;
                    $display("FAIL rest_step1 got g=%b f=%0d exp g=0 f=22", gate, frequency);
                end
            end
        end
        run = 0;
        cycle();
    endtask

    task automatic test_short_step();
        int sc = 0;
        step_len = 1; run = 1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            sc += int'(step_strobe);
            checks++;
            if (gate !== 1'b0 || step !== 4'(m_step) || step_strobe !== m_strobe) begin
                failures++;
                $display("FAIL short_step got g=%b s=%0d st=%b exp g=0 s=%0d st=%b",
                         gate, step, step_strobe, m_step, m_strobe);
            end
        end
        checks++;
        if (sc != 6) begin
            failures++;
            $display("FAIL short_step_strobes got %0d exp 6", sc);
        end
        run = 0;
        cycle();
    endtask

    task automatic test_stop_restart();
        bit found = 0;
        step_len = 3; run = 1;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (m_step == 5 && m_tick == 1) found = 1;
        end
        checks++;
        if (!found || step !== 4'd5) begin
            failures++;
            $display("FAIL stop_reach got s=%0d exp 5 within 60 cycles", step);
        end
        run = 0;
        cycle();
        checks++;
        if (gate !== 1'b0 || step !== 4'd5 || running !== 1'b0 || step_strobe !== 1'b0) begin
            failures++;
            $display("FAIL stop got g=%b s=%0d r=%b st=%b exp g=0 s=5 r=0 st=0",
                     gate, step, running, step_strobe);
        end
        run = 1;
        cycle();
        checks++;
        if (step !== 4'd0 || step_strobe !== 1'b1 || running !== 1'b1) begin
            failures++;
            $display("FAIL restart got s=%0d st=%b r=%b exp s=0 st=1 r=1",
                     step, step_strobe, running);
        end
        run = 0;
        cycle();
    endtask

    task automatic test_wrap_collision();
        bit found = 0;
`ifdef SID_SEQ_LOOP_LEN_EN
        last_step = 3;
`endif
        step_len = 0; prescaler = 16'hFFFF; run = 1;
        cycle();
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_step == last_step) found = 1;
            else cycle();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wrap_reach got s=%0d exp %0d", step, last_step);
        end
        wr_en = 1; wr_addr = 0; wr_data = 8'h05;
        cycle();
        wr_en = 0;
        checks++;
        if (step !== 4'd0 || frequency !== 7'd22 || step_strobe !== 1'b1) begin
            failures++;
            $display("FAIL wrap_old got s=%0d f=%0d st=%b exp s=0 f=22 st=1",
                     step, frequency, step_strobe);
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (m_step == 0) found = 1;
        end
        checks++;
        if (!found || step !== 4'd0 || frequency !== 7'd5) begin
            failures++;
            $display("FAIL wrap_new got s=%0d f=%0d exp s=0 f=5", step, frequency);
        end
        run = 0;
        cycle();
        last_step = 15;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            prescaler = ($urandom_range(2) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(19) == 0) run = ~run;
            wr_en = ($urandom_range(4) == 0);
            wr_addr = 4'($urandom);
            wr_data = 8'($urandom);
            if ($urandom_range(29) == 0) step_len = 8'($urandom_range(5));
            rst_n = ($urandom_range(199) != 0);
`ifdef SID_SEQ_LOOP_LEN_EN
            if ($urandom_range(49) == 0) last_step = $urandom_range(15);
`endif
            cycle();
            checks++;
            if ({frequency, gate, step, step_strobe, running} !==
                {7'(m_freq), m_gate, 4'(m_step), m_strobe, m_play}) begin
                failures++;
                $display("FAIL random i=%0d got f=%0d g=%b s=%0d st=%b r=%b exp f=%0d g=%b s=%0d st=%b r=%b",
                         i, frequency, gate, step, step_strobe, running,
                         m_freq, m_gate, m_step, m_strobe, m_play);
            end
        end
        rst_n = 1; wr_en = 0;
    endtask

    initial begin
        m_play = 0; m_rest = 1; m_gate = 0; m_strobe = 0;
        m_step = 0; m_tick = 0; m_freq = 0;
        foreach (m_pat[i]) m_pat[i] = 8'h80;
        rst_n = 0; run = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        prescaler = 0; step_len = 0;
        test_reset();
        test_basic_play();
        test_rest();
        test_short_step();
        test_stop_restart();
        test_wrap_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
